// File: rtl/mem_arbiter.sv
// Shared main-memory port arbiter: I-cache line refills versus data-side single-word accesses.
// Optional ARB_RR_EN: round-robin between the two sides when both are pending, instead of data priority.
module mem_arbiter #(
  parameter int LATENCY     = 20,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ireq,
  input  logic [31:0]                    iaddr,
  output logic [31:0]                    irdata,
  output logic                           iwvalid,
  output logic [$clog2(BLOCK_WORDS)-1:0] iwidx,
  output logic                           idone,
  input  logic                           dreq,
  input  logic                           dwe,
  input  logic [31:0]                    daddr,
  input  logic [31:0]                    dwdata,
  output logic [31:0]                    drdata,
  output logic                           ddone,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [31:0]                    mem_addr,
  output logic [31:0]                    mem_wdata,
  input  logic [31:0]                    mem_rdata,
  output logic                           busy
);

  // state  | meaning
  // IDLE   | no access; arbitrate pending requests
  // DACC   | data word access, counting down LATENCY cycles
  // DRESP  | ddone pulse
  // IBURST | refill words back to back, LATENCY cycles each
  // IRESP  | last refill word valid plus idone pulse

  localparam int WW = $clog2(BLOCK_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(LATENCY - 1);
  localparam logic [WW-1:0] WIDX_LAST = WW'(BLOCK_WORDS - 1);
  localparam logic [31:0]   LINE_MASK = 32'(BLOCK_WORDS * 4 - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DACC   = 3'd1,
    DRESP  = 3'd2,
    IBURST = 3'd3,
    IRESP  = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [WW-1:0] widx;
  logic [31:0]   line_q;
  logic [31:0]   daddr_q;
  logic [31:0]   dwdata_q;
  logic          dwe_q;
  logic          iwv_q;
  logic          grant_d;
  logic          grant_i;
  logic          pick_d;
  logic [31:0]   word_addr;

`ifdef ARB_RR_EN
  // 1 = data side was served last; resets to the instruction side
  logic last_grant;

  assign pick_d = dreq && (!ireq || !last_grant);

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= 1'b0;
    end else if (grant_d) begin
      last_grant <= 1'b1;
    end else if (grant_i) begin
      last_grant <= 1'b0;
    end
  end
`else
  assign pick_d = dreq;
`endif

  // Line base is aligned, so OR-ing in the word offset cannot carry.
  assign word_addr = (line_q & ~LINE_MASK) | {{(30-WW){1'b0}}, widx, 2'b00};

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    ddone     = 1'b0;
    idone     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_d) begin
          grant_d = 1'b1;
          state_n = DACC;
        end else if (ireq) begin
          grant_i = 1'b1;
          state_n = IBURST;
        end
      end
      DACC: begin
        mem_en    = 1'b1;
        mem_we    = dwe_q;
        mem_addr  = daddr_q;
        mem_wdata = dwdata_q;
        if (cnt == '0) state_n = DRESP;
      end
      DRESP: begin
        ddone   = 1'b1;
        state_n = IDLE;
      end
      IBURST: begin
        mem_en   = 1'b1;
        mem_addr = word_addr;
        if (cnt == '0 && widx == WIDX_LAST) state_n = IRESP;
      end
      IRESP: begin
        idone   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      widx     <= '0;
      line_q   <= 32'd0;
      daddr_q  <= 32'd0;
      dwdata_q <= 32'd0;
      dwe_q    <= 1'b0;
      drdata   <= 32'd0;
      irdata   <= 32'd0;
      iwidx    <= '0;
      iwv_q    <= 1'b0;
    end else begin
      iwv_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            daddr_q  <= daddr;
            dwdata_q <= dwdata;
            dwe_q    <= dwe;
            cnt      <= CNT_LOAD;
          end else if (grant_i) begin
            line_q <= iaddr;
            widx   <= '0;
            cnt    <= CNT_LOAD;
          end
        end
        DACC: begin
          if (cnt == '0) begin
            if (!dwe_q) drdata <= mem_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        IBURST: begin
          if (cnt == '0) begin
            irdata <= mem_rdata;
            iwidx  <= widx;
            // the last word's iwvalid comes from IRESP alongside idone
            if (widx != WIDX_LAST) begin
              iwv_q <= 1'b1;
              widx  <= widx + 1'b1;
              cnt   <= CNT_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign iwvalid = iwv_q | idone;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LATENCY=4/BLOCK_WORDS=4 instance plus a LATENCY=1/BLOCK_WORDS=2 instance.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0;
  logic [31:0] iaddr = 32'd0, daddr = 32'd0, dwdata = 32'd0;

  logic [31:0] irdata, drdata, mem_addr, mem_wdata, mem_rdata;
  logic        iwvalid, idone, ddone, mem_en, mem_we, busy;
  logic [1:0]  iwidx;

  logic        ireq1 = 1'b0, dreq1 = 1'b0;
  logic [31:0] irdata1, drdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        iwvalid1, idone1, ddone1, mem_en1, mem_we1, busy1;
  logic [0:0]  iwidx1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: one fixed word at 0x100, otherwise address XOR a constant.
  assign mem_rdata  = (mem_addr  == 32'h100) ? 32'hDEADBEEF : (mem_addr  ^ 32'hA5A5_0000);
  assign mem_rdata1 = (mem_addr1 == 32'h100) ? 32'hDEADBEEF : (mem_addr1 ^ 32'hA5A5_0000);

  mem_arbiter #(.LATENCY(4), .BLOCK_WORDS(4)) u_dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .iwvalid(iwvalid), .iwidx(iwidx), .idone(idone),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .drdata(drdata), .ddone(ddone),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.LATENCY(1), .BLOCK_WORDS(2)) u_dut1 (
    .clk(clk), .reset(reset),
    .ireq(ireq1), .iaddr(iaddr), .irdata(irdata1), .iwvalid(iwvalid1), .iwidx(iwidx1), .idone(idone1),
    .dreq(dreq1), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .drdata(drdata1), .ddone(ddone1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic        e_iwv;
    logic [31:0] e_addr;
    int          idx;

    // reset
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_ddone", {31'd0, ddone}, 32'd0);
    chk("rst_idone", {31'd0, idone}, 32'd0);
    chk("rst_iwvalid", {31'd0, iwvalid}, 32'd0);
    chk("rst_drdata", drdata, 32'd0);
    chk("rst_irdata", irdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    reset = 1'b1;
    step();

    // 1: data read
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h100;
    chk("t1_c0_mem_en", {31'd0, mem_en}, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("t1_mem_en", {31'd0, mem_en}, 32'd1);
      chk("t1_mem_addr", mem_addr, 32'h100);
      chk("t1_mem_we", {31'd0, mem_we}, 32'd0);
      chk("t1_ddone_early", {31'd0, ddone}, 32'd0);
      chk("t1_iwvalid", {31'd0, iwvalid}, 32'd0);
    end
    step();
    chk("t1_ddone", {31'd0, ddone}, 32'd1);
    chk("t1_drdata", drdata, 32'hDEADBEEF);
    chk("t1_c5_mem_en", {31'd0, mem_en}, 32'd0);
    dreq = 1'b0;
    step();
    chk("t1_ddone_after", {31'd0, ddone}, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // 2: data write
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h200; dwdata = 32'h12345678;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("t2_mem_we", {31'd0, mem_we}, 32'd1);
      chk("t2_mem_wdata", mem_wdata, 32'h12345678);
      chk("t2_mem_addr", mem_addr, 32'h200);
      chk("t2_ddone_early", {31'd0, ddone}, 32'd0);
    end
    step();
    chk("t2_ddone", {31'd0, ddone}, 32'd1);
    chk("t2_drdata_hold", drdata, 32'hDEADBEEF);
    dreq = 1'b0; dwe = 1'b0;
    step();
    chk("t2_idle", {31'd0, busy}, 32'd0);

    // 3: line refill from 0x40C (base 0x400)
    ireq = 1'b1; iaddr = 32'h40C;
    for (int c = 1; c <= 17; c++) begin
      step();
      e_addr = (c <= 16) ? (32'h400 + 32'(4 * ((c - 1) / 4))) : 32'd0;
      e_iwv  = (c == 5 || c == 9 || c == 13 || c == 17);
      chk("t3_mem_en", {31'd0, mem_en}, {31'd0, (c <= 16)});
      chk("t3_mem_addr", mem_addr, e_addr);
      chk("t3_mem_we", {31'd0, mem_we}, 32'd0);
      chk("t3_iwvalid", {31'd0, iwvalid}, {31'd0, e_iwv});
      chk("t3_idone", {31'd0, idone}, {31'd0, (c == 17)});
      if (e_iwv) begin
        idx = (c - 5) / 4;
        chk("t3_iwidx", {30'd0, iwidx}, 32'(idx));
        chk("t3_irdata", irdata, (32'h400 + 32'(4 * idx)) ^ 32'hA5A5_0000);
      end
    end
    ireq = 1'b0;
    step();
    chk("t3_idle", {31'd0, busy}, 32'd0);
    chk("t3_iwvalid_after", {31'd0, iwvalid}, 32'd0);
    chk("t3_drdata_hold", drdata, 32'hDEADBEEF);

    // 4: simultaneous requests, data first
    ireq = 1'b1; iaddr = 32'h500;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h300;
    for (int c = 1; c <= 23; c++) begin
      step();
      chk("t4_ddone", {31'd0, ddone}, {31'd0, (c == 5)});
      chk("t4_idone", {31'd0, idone}, {31'd0, (c == 23)});
      chk("t4_busy", {31'd0, busy}, {31'd0, (c != 6)});
      if (c == 5) begin
        chk("t4_drdata", drdata, 32'hA5A5_0300);
        dreq = 1'b0;
      end
      if (c == 7) chk("t4_burst_addr", mem_addr, 32'h500);
    end
    ireq = 1'b0;
    step();

    // 5: dreq raised mid-burst waits
    ireq = 1'b1; iaddr = 32'h800;
    for (int c = 1; c <= 23; c++) begin
      step();
      chk("t5_idone", {31'd0, idone}, {31'd0, (c == 17)});
      chk("t5_ddone", {31'd0, ddone}, {31'd0, (c == 23)});
      chk("t5_busy", {31'd0, busy}, {31'd0, (c != 18)});
      if (c == 6) begin
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h104;
      end
      if (c == 17) ireq = 1'b0;
      if (c >= 19 && c <= 22) chk("t5_daddr", mem_addr, 32'h104);
      if (c == 23) begin
        chk("t5_drdata", drdata, 32'hA5A5_0104);
        dreq = 1'b0;
      end
    end
    step();

    // 6: reset mid-burst
    ireq = 1'b1; iaddr = 32'h400;
    step(); step(); step();
    chk("t6_c3_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    step();
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_mem_en", {31'd0, mem_en}, 32'd0);
    chk("t6_iwvalid", {31'd0, iwvalid}, 32'd0);
    chk("t6_idone", {31'd0, idone}, 32'd0);
    chk("t6_irdata", irdata, 32'd0);
    chk("t6_drdata", drdata, 32'd0);
    reset = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      step();
      chk("t6_fresh_idone", {31'd0, idone}, {31'd0, (c == 17)});
    end
    ireq = 1'b0;
    step();
    chk("t6_idle", {31'd0, busy}, 32'd0);

    // 7: LATENCY=1, BLOCK_WORDS=2
    dreq1 = 1'b1; dwe = 1'b0; daddr = 32'h100;
    step();
    chk("t7_d_mem_en", {31'd0, mem_en1}, 32'd1);
    chk("t7_d_addr", mem_addr1, 32'h100);
    chk("t7_d_ddone_early", {31'd0, ddone1}, 32'd0);
    step();
    chk("t7_ddone", {31'd0, ddone1}, 32'd1);
    chk("t7_drdata", drdata1, 32'hDEADBEEF);
    dreq1 = 1'b0;
    step();
    chk("t7_d_idle", {31'd0, busy1}, 32'd0);
    ireq1 = 1'b1; iaddr = 32'h404;
    step();
    chk("t7_i_c1_addr", mem_addr1, 32'h400);
    chk("t7_i_c1_iwv", {31'd0, iwvalid1}, 32'd0);
    step();
    chk("t7_i_c2_addr", mem_addr1, 32'h404);
    chk("t7_i_c2_iwv", {31'd0, iwvalid1}, 32'd1);
    chk("t7_i_c2_idx", {31'd0, iwidx1}, 32'd0);
    chk("t7_i_c2_data", irdata1, 32'hA5A5_0400);
    chk("t7_i_c2_idone", {31'd0, idone1}, 32'd0);
    step();
    chk("t7_i_c3_iwv", {31'd0, iwvalid1}, 32'd1);
    chk("t7_i_c3_idone", {31'd0, idone1}, 32'd1);
    chk("t7_i_c3_idx", {31'd0, iwidx1}, 32'd1);
    chk("t7_i_c3_data", irdata1, 32'hA5A5_0404);
    chk("t7_i_c3_mem_en", {31'd0, mem_en1}, 32'd0);
    ireq1 = 1'b0;
    step();
    chk("t7_i_idle", {31'd0, busy1}, 32'd0);
    chk("t7_i_iwv_after", {31'd0, iwvalid1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
